spi_frame_master: RTL
=====================

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

Interface
REQ-001 SHALL have parameter NBYTES, default 7, payload bytes per frame (legal 1..255).
REQ-002 SHALL have parameter CLK_DIV, default 5, clk cycles per SCLK half-period (legal >=1).
REQ-003 SHALL have parameter CS_START, default 10, clk cycles from cs_b fall to first byte load (legal >=1).
REQ-004 SHALL have parameter CS_STOP, default 10, clk cycles from last SCLK fall to cs_b rise (legal >=1).
REQ-005 SHALL have parameter CRC_EN, default 1, append/check CRC byte when 1.
REQ-006 SHALL have parameters CRC_POLY, default 8'h2f, and CRC_SEED, default 8'hff.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk input 1, system clock; rst input 1, synchronous active-high reset.
REQ-008 SHALL have ports: start in 1, frame request pulse; tx_data in 8, payload byte; tx_valid in 1; tx_ready out 1.
REQ-009 SHALL have ports: rx_data out 8, received byte; rx_valid out 1, one-cycle strobe; rx_last out 1, set with final rx_valid of frame.
REQ-010 SHALL have ports: busy out 1; done out 1, one-cycle pulse; crc_err out 1; frame_count out 16.
REQ-011 SHALL have ports: cs_b out 1, active-low select; sclk out 1; mosi out 1; miso in 1.

Function
REQ-012 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first; bit period 2*CLK_DIV clk cycles.
REQ-013 SHALL use states IDLE, CS_SETUP, LOAD, SHIFT, CRC_SHIFT, CS_HOLD.
REQ-014 IDLE: cs_b=1, sclk=0, mosi=0, busy=0; start=1 -> CS_SETUP with cs_b=0 next cycle; start ignored in all other states.
REQ-015 CS_SETUP SHALL last CS_START cycles, then -> LOAD.
REQ-016 LOAD: tx_ready=1 only here; on tx_valid&tx_ready capture tx_data, update tx CRC, -> SHIFT; tx_valid=0 stalls with cs_b=0, sclk=0 indefinitely.
REQ-017 SHIFT: mosi driven while sclk low; sclk rises after CLK_DIV cycles; miso sampled on cycle sclk rises; sclk falls CLK_DIV cycles later, next bit on mosi same cycle.
REQ-018 After 8th sclk fall SHALL assert rx_valid one cycle with assembled byte and update rx CRC.
REQ-019 After payload byte k<NBYTES -> LOAD; after byte NBYTES -> CRC_SHIFT if CRC_EN else CS_HOLD.
REQ-020 CRC_SHIFT SHALL transmit accumulated tx CRC without handshake, timing per REQ-017, rx_valid and rx_last on completion, -> CS_HOLD.
REQ-021 rx_last SHALL accompany rx_valid of the last byte shifted (CRC byte if CRC_EN, else payload byte NBYTES).
REQ-022 CRC: non-reflected, MSB first, per bit c = (c<<1) ^ (CRC_POLY if data_bit^c[7]), seed CRC_SEED per frame, no final XOR.
REQ-023 crc_err SHALL update on done: 1 if rx CRC over all NBYTES+1 received bytes != 0, else 0; held until next done; stays 0 if CRC_EN=0.
REQ-024 CS_HOLD SHALL last CS_STOP cycles, then cs_b=1, done=1 one cycle, frame_count+1 (wraps 16'hffff -> 0), -> IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start asserted same cycle as done SHALL be ignored; a new frame requires start in IDLE.

Reset
REQ-027 rst SHALL force within one clk edge: state IDLE, cs_b=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_last=0, rx_data=0, done=0, busy=0, crc_err=0, frame_count=0.
REQ-028 rst mid-frame SHALL abort with no done, no frame_count increment, no rx_valid.

Verification
REQ-029 NBYTES=1, CLK_DIV=2, miso looped to mosi, tx 8'h00 -> mosi bytes 00,42; rx_valid twice (00, 42, rx_last on second); crc_err=0; frame_count=1.
REQ-030 Same, miso forced 0 -> rx 00,00; crc_err=1 at done.
REQ-031 NBYTES=3, CRC_EN=0, tx A5,3C,FF -> 24 sclk rising edges, each high exactly CLK_DIV cycles; no CRC byte; crc_err=0.
REQ-032 tx_valid withheld 50 cycles in LOAD -> cs_b stays 0, sclk stays 0, no edges; frame completes normally after tx_valid.
REQ-033 rst asserted mid-SHIFT -> cs_b=1, sclk=0, busy=0 next cycle; done never pulses; frame_count unchanged.
REQ-034 start pulsed during busy and in done cycle -> ignored; frame_count preset near 16'hffff wraps to 0 after done.

Source files
------------

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: one chip-select window carries NBYTES payload bytes
// plus an optional CRC-8 byte, with full-duplex receive and CRC checking.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | cs_b high, waiting for start
// CS_SETUP  | cs_b low, CS_START cycles before the first byte
// LOAD      | tx_ready high, waiting for tx_valid (may stall indefinitely)
// SHIFT     | shifting one payload byte, 8 SCLK periods
// CRC_SHIFT | shifting the accumulated tx CRC byte
// CS_HOLD   | CS_STOP cycles after the last SCLK fall, then done
module spi_frame_master #(
  parameter int          NBYTES           = 7,
  parameter int          CLK_DIV          = 5,
  parameter int          CS_START         = 10,
  parameter int          CS_STOP          = 10,
  parameter int          CRC_EN           = 1,
  parameter logic [7:0]  CRC_POLY         = 8'h2f,
  parameter logic [7:0]  CRC_SEED         = 8'hff,
  // frame_count value loaded by rst; leave at 0 outside of test benches
  parameter logic [15:0] FRAME_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic [15:0] frame_count,
  output logic        cs_b,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOAD,
    SHIFT,
    CRC_SHIFT,
    CS_HOLD
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  byte_idx;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  tx_crc;
  logic [7:0]  rx_crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (data[i] ^ c[7]) c = (c << 1) ^ CRC_POLY;
      else                c = c << 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cs_b        <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      rx_data     <= 8'h00;
      done        <= 1'b0;
      busy        <= 1'b0;
      crc_err     <= 1'b0;
      frame_count <= FRAME_COUNT_INIT;
      cnt         <= 16'h0000;
      bit_idx     <= 3'd0;
      byte_idx    <= 8'h00;
      tx_sh       <= 8'h00;
      rx_sh       <= 8'h00;
      tx_crc      <= CRC_SEED;
      rx_crc      <= CRC_SEED;
    end else begin
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // done is high in the first IDLE cycle; a start there is dropped
          if (start && !done) begin
            state    <= CS_SETUP;
            cs_b     <= 1'b0;
            busy     <= 1'b1;
            cnt      <= 16'(CS_START - 1);
            byte_idx <= 8'h00;
            tx_crc   <= CRC_SEED;
            rx_crc   <= CRC_SEED;
          end
        end
        CS_SETUP: begin
          if (cnt == 16'h0000) begin
            state    <= LOAD;
            tx_ready <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        LOAD: begin
          if (tx_valid) begin
            tx_ready <= 1'b0;
            tx_sh    <= tx_data;
            mosi     <= tx_data[7];
            tx_crc   <= crc8_byte(tx_crc, tx_data);
            bit_idx  <= 3'd0;
            cnt      <= 16'(CLK_DIV - 1);
            state    <= SHIFT;
          end
        end
        SHIFT, CRC_SHIFT: begin
          if (cnt != 16'h0000) begin
            cnt <= cnt - 16'd1;
          end else begin
            cnt  <= 16'(CLK_DIV - 1);
            sclk <= ~sclk;
            if (!sclk) begin
              rx_sh <= {rx_sh[6:0], miso};
            end else if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              mosi    <= tx_sh[6];
            end else begin
              // eighth falling edge: byte complete
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
              rx_crc   <= crc8_byte(rx_crc, rx_sh);
              bit_idx  <= 3'd0;
              mosi     <= 1'b0;
              if (state == CRC_SHIFT) begin
                rx_last <= 1'b1;
                state   <= CS_HOLD;
                cnt     <= 16'(CS_STOP - 1);
              end else if (byte_idx != 8'(NBYTES - 1)) begin
                byte_idx <= byte_idx + 8'd1;
                state    <= LOAD;
                tx_ready <= 1'b1;
              end else if (CRC_EN != 0) begin
                state <= CRC_SHIFT;
                tx_sh <= tx_crc;
                mosi  <= tx_crc[7];
              end else begin
                rx_last <= 1'b1;
                state   <= CS_HOLD;
                cnt     <= 16'(CS_STOP - 1);
              end
            end
          end
        end
        CS_HOLD: begin
          if (cnt == 16'h0000) begin
            state       <= IDLE;
            cs_b        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_count <= frame_count + 16'd1;
            crc_err     <= (CRC_EN != 0) && (rx_crc != 8'h00);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
